// File: rtl/sft_seq.sv
// sft_seq: autonomous command sequencer feeding a 74HC595-style shift engine from a Wishbone-loaded byte FIFO.
// Define SFT_SEQ_REPEAT_EN to enable the REPEAT (looping pass) feature.
module sft_seq #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        SEQ_STB_I,
    input  logic        SEQ_WE_I,
    input  logic [5:0]  SEQ_ADR_I,
    input  logic [31:0] SEQ_DAT_I,
    output logic        SEQ_ACK_O,
    output logic [31:0] SEQ_DAT_O,
    output logic        SEQ_INT,
    output logic        SFT_VLD,
    output logic [1:0]  SFT_CMD,
    output logic        SFT_OEN,
    output logic [7:0]  SFT_DIN,
    input  logic        SFT_DONE
);
`ifdef SFT_SEQ_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, MR, SHIFT, STORE, OE, WAIT, FIN} state_t;
    state_t st_q, st_d;
    logic ack_q, ack_d, vld_q, vld_d, oen_q, oen_d;
    logic done_q, done_d, ovf_q, ovf_d, err_q, err_d, mask_q, mask_d, mrf_q, mrf_d, rep_q, rep_d;
    logic [31:0] dat_q, dat_d;
    logic [1:0] cmd_q, cmd_d;
    logic [7:0] din_q, din_d;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d, srd_q, srd_d, swr_q, swr_d;
    logic [4:0] cnt_q, cnt_d, scnt_q, scnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0] mem [DEPTH];
    logic acc, wr_data, wr_ctrl, busy, empty, full, start, push, pop;
    logic [31:0] stat;
    logic unused_dat;
    assign unused_dat = ^SEQ_DAT_I[31:9];
    assign acc     = SEQ_STB_I & ~ack_q;
    assign wr_data = acc & SEQ_WE_I & (SEQ_ADR_I == 6'h00);
    assign wr_ctrl = acc & SEQ_WE_I & (SEQ_ADR_I == 6'h04);
    assign busy    = st_q != IDLE;
    assign empty   = cnt_q == 5'd0;
    assign full    = cnt_q == 5'(DEPTH);
    assign start   = wr_ctrl & SEQ_DAT_I[0] & ~busy;
    assign pop     = (st_q == SHIFT) & ~empty;
    // a pop in the same cycle frees the slot, so a push at full still fits
    assign push    = wr_data & (~full | pop);
    assign stat    = {21'd0, rep_q, empty, err_q, ovf_q, done_q, busy, cnt_q};
    assign SEQ_ACK_O = ack_q;
    assign SEQ_DAT_O = dat_q;
    assign SEQ_INT   = ~mask_q & (done_q | err_q);
    assign SFT_VLD   = vld_q;
    assign SFT_CMD   = cmd_q;
    assign SFT_OEN   = oen_q;
    assign SFT_DIN   = din_q;
    always_comb begin
        st_d = st_q;
        ack_d = acc;
        dat_d = (acc & ~SEQ_WE_I & (SEQ_ADR_I == 6'h08)) ? stat : 32'd0;
        vld_d = 1'b0;
        cmd_d = cmd_q;
        oen_d = oen_q;
        din_d = din_q;
        rd_d = rd_q;
        wr_d = wr_q;
        cnt_d = cnt_q;
        done_d = done_q;
        ovf_d = ovf_q;
        err_d = err_q;
        mask_d = mask_q;
        mrf_d = mrf_q;
        rep_d = rep_q;
        srd_d = srd_q;
        swr_d = swr_q;
        scnt_d = scnt_q;
        tmo_d = tmo_q;
        if (wr_ctrl) begin
            mask_d = SEQ_DAT_I[3];
            if (SEQ_DAT_I[4]) begin
                done_d = 1'b0;
                ovf_d = 1'b0;
                err_d = 1'b0;
            end
            if (SEQ_DAT_I[8] && !busy) begin
                rd_d = '0;
                wr_d = '0;
                cnt_d = '0;
            end
            if (!SEQ_DAT_I[5]) rep_d = 1'b0;
        end
        if (wr_data && !push) ovf_d = 1'b1;
        if (push) wr_d = wr_q + 1'b1;
        if (pop) begin
            rd_d = rd_q + 1'b1;
            din_d = mem[rd_q];
        end
        cnt_d = cnt_d + 5'(push) - 5'(pop);
        case (st_q)
            IDLE: if (start) begin
                mrf_d = SEQ_DAT_I[2];
                oen_d = SEQ_DAT_I[1];
                rep_d = REP_EN & SEQ_DAT_I[5];
                srd_d = rd_q;
                swr_d = wr_q;
                scnt_d = cnt_q;
                st_d = SEQ_DAT_I[2] ? MR : !empty ? SHIFT : STORE;
            end
            MR, SHIFT, STORE, OE: begin
                vld_d = 1'b1;
                cmd_d = st_q == MR ? 2'd0 : st_q == SHIFT ? 2'd1 : st_q == STORE ? 2'd2 : 2'd3;
                st_d = WAIT;
            end
            // tmo_q counts cycles since the VLD cycle; DONE is ignored during VLD itself
            WAIT: if (vld_q) tmo_d = TW'(1);
            else if (SFT_DONE) st_d = cmd_q == 2'd2 ? OE : cmd_q == 2'd3 ? FIN : cnt_d != 5'd0 ? SHIFT : STORE;
            else if (tmo_q == TW'(TIMEOUT)) begin
                err_d = 1'b1;
                rep_d = 1'b0;
                st_d = IDLE;
            end
            else tmo_d = tmo_q + 1'b1;
            FIN: begin
                done_d = 1'b1;
                st_d = IDLE;
                if (rep_d) begin
                    rd_d = srd_q;
                    wr_d = swr_q;
                    cnt_d = scnt_q;
                    st_d = mrf_q ? MR : scnt_q != 5'd0 ? SHIFT : STORE;
                end
            end
            default: st_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            st_q <= IDLE;
            ack_q <= 1'b0;
            dat_q <= '0;
            vld_q <= 1'b0;
            cmd_q <= 2'd0;
            oen_q <= 1'b1;
            din_q <= '0;
            rd_q <= '0;
            wr_q <= '0;
            cnt_q <= '0;
            done_q <= 1'b0;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
            mask_q <= 1'b1;
            mrf_q <= 1'b0;
            rep_q <= 1'b0;
            srd_q <= '0;
            swr_q <= '0;
            scnt_q <= '0;
            tmo_q <= '0;
        end else begin
            st_q <= st_d;
            ack_q <= ack_d;
            dat_q <= dat_d;
            vld_q <= vld_d;
            cmd_q <= cmd_d;
            oen_q <= oen_d;
            din_q <= din_d;
            rd_q <= rd_d;
            wr_q <= wr_d;
            cnt_q <= cnt_d;
            done_q <= done_d;
            ovf_q <= ovf_d;
            err_q <= err_d;
            mask_q <= mask_d;
            mrf_q <= mrf_d;
            rep_q <= rep_d;
            srd_q <= srd_d;
            swr_q <= swr_d;
            scnt_q <= scnt_d;
            tmo_q <= tmo_d;
        end
    end
    always_ff @(posedge CLK_I) begin
        if (push) mem[wr_q] <= SEQ_DAT_I[7:0];
    end
endmodule

// File: tb/tb_sft_seq.sv
// tb_sft_seq: directed self-checking bench for sft_seq with a shift-engine DONE responder.
module tb_sft_seq;
    logic CLK_I, RST_I, SEQ_STB_I, SEQ_WE_I, SEQ_ACK_O, SEQ_INT, SFT_VLD, SFT_OEN, SFT_DONE;
    logic [5:0] SEQ_ADR_I;
    logic [31:0] SEQ_DAT_I, SEQ_DAT_O, rd;
    logic [1:0] SFT_CMD;
    logic [7:0] SFT_DIN;
    int n_tests, n_fail, nv, cyc, dly, n0, bad;
    logic done_en;
    logic [1:0] lc [64];
    logic [7:0] ld [64];
    logic lo [64];
    int lt [64];

    sft_seq #(.DEPTH(8), .TIMEOUT(16)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .SEQ_STB_I(SEQ_STB_I), .SEQ_WE_I(SEQ_WE_I),
        .SEQ_ADR_I(SEQ_ADR_I), .SEQ_DAT_I(SEQ_DAT_I), .SEQ_ACK_O(SEQ_ACK_O), .SEQ_DAT_O(SEQ_DAT_O),
        .SEQ_INT(SEQ_INT), .SFT_VLD(SFT_VLD), .SFT_CMD(SFT_CMD), .SFT_OEN(SFT_OEN),
        .SFT_DIN(SFT_DIN), .SFT_DONE(SFT_DONE)
    );

    initial CLK_I = 1'b0;
    always #5 CLK_I = ~CLK_I;
    always @(posedge CLK_I) cyc++;

    // engine model: DONE pulse 4 cycles after each VLD
    always @(negedge CLK_I) begin
        SFT_DONE = 1'b0;
        if (RST_I) dly = 0;
        else if (SFT_VLD && done_en) dly = 4;
        else if (dly > 0) begin
            dly--;
            if (dly == 0) SFT_DONE = 1'b1;
        end
    end

    always @(negedge CLK_I) begin
        if (SFT_VLD && nv < 64) begin
            lc[nv] = SFT_CMD;
            ld[nv] = SFT_DIN;
            lo[nv] = SFT_OEN;
            lt[nv] = cyc;
            nv++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wb_wr(input logic [5:0] a, input logic [31:0] d);
        @(negedge CLK_I);
        SEQ_STB_I = 1'b1; SEQ_WE_I = 1'b1; SEQ_ADR_I = a; SEQ_DAT_I = d;
        @(negedge CLK_I);
        SEQ_STB_I = 1'b0; SEQ_WE_I = 1'b0;
    endtask

    task automatic wb_rd(input logic [5:0] a, output logic [31:0] d);
        @(negedge CLK_I);
        SEQ_STB_I = 1'b1; SEQ_WE_I = 1'b0; SEQ_ADR_I = a;
        @(negedge CLK_I);
        d = SEQ_DAT_O;
        SEQ_STB_I = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] s;
        int k;
        k = 0;
        s = 32'h20;
        while (s[5] && k < 300) begin
            wb_rd(6'h08, s);
            k++;
        end
        if (s[5]) chk(tag, 32'd1, 32'd0);
    endtask

    task automatic wait_nv(input int n, input string tag);
        int k;
        k = 0;
        while (nv < n && k < 500) begin
            @(negedge CLK_I);
            #1;
            k++;
        end
        if (nv < n) chk(tag, 32'(nv), 32'(n));
    endtask

    initial begin
        n_tests = 0; n_fail = 0; nv = 0; cyc = 0; dly = 0; done_en = 1'b0;
        RST_I = 1'b1; SEQ_STB_I = 1'b0; SEQ_WE_I = 1'b0; SEQ_ADR_I = '0; SEQ_DAT_I = '0;
        repeat (2) @(negedge CLK_I);
        chk("rst_ack", 32'(SEQ_ACK_O), 32'd0);
        chk("rst_dat", SEQ_DAT_O, 32'd0);
        chk("rst_int", 32'(SEQ_INT), 32'd0);
        chk("rst_vld", 32'(SFT_VLD), 32'd0);
        chk("rst_cmd", 32'(SFT_CMD), 32'd0);
        chk("rst_oen", 32'(SFT_OEN), 32'd1);
        chk("rst_din", 32'(SFT_DIN), 32'd0);
        RST_I = 1'b0;
        wb_rd(6'h08, rd);
        chk("rst_stat", rd, 32'h200);
        wb_rd(6'h10, rd);
        chk("bad_addr_rd", rd, 32'd0);

        // 1: MR_FIRST sequence with two bytes
        done_en = 1'b1;
        wb_wr(6'h00, 32'hA5);
        wb_wr(6'h00, 32'h3C);
        nv = 0;
        wb_wr(6'h04, 32'h05);
        wait_idle("t1_idle");
        chk("t1_nv", 32'(nv), 32'd5);
        chk("t1_c0", 32'(lc[0]), 32'd0);
        chk("t1_c1", {22'd0, lc[1], ld[1]}, 32'h1A5);
        chk("t1_c2", {22'd0, lc[2], ld[2]}, 32'h13C);
        chk("t1_c3", 32'(lc[3]), 32'd2);
        chk("t1_c4", {30'd0, lc[4]}, 32'd3);
        chk("t1_oen", 32'(lo[4]), 32'd0);
        wb_rd(6'h08, rd);
        chk("t1_stat", rd, 32'h240);
        chk("t1_int", 32'(SEQ_INT), 32'd1);

        // 2: clear sticky bits
        wb_wr(6'h04, 32'h10);
        chk("t2_int", 32'(SEQ_INT), 32'd0);
        wb_rd(6'h08, rd);
        chk("t2_stat", rd, 32'h200);

        // 3: overflow and full FIFO drain
        for (int i = 0; i < 9; i++) wb_wr(6'h00, 32'h10 + 32'(i));
        wb_rd(6'h08, rd);
        chk("t3_stat_full", rd, 32'h088);
        nv = 0;
        wb_wr(6'h04, 32'h01);
        wait_idle("t3_idle");
        chk("t3_nv", 32'(nv), 32'd10);
        for (int i = 0; i < 8; i++) chk($sformatf("t3_sh%0d", i), {22'd0, lc[i], ld[i]}, 32'h110 + 32'(i));
        chk("t3_store", 32'(lc[8]), 32'd2);
        wb_rd(6'h08, rd);
        chk("t3_stat", rd, 32'h2C0);
        wb_wr(6'h04, 32'h10);

        // 4: timeout with engine silent
        done_en = 1'b0;
        wb_wr(6'h00, 32'h55);
        wb_wr(6'h00, 32'h66);
        nv = 0;
        wb_wr(6'h04, 32'h01);
        begin
            int k;
            k = 0;
            while (!SEQ_INT && k < 100) begin
                @(negedge CLK_I);
                k++;
            end
            chk("t4_int", 32'(SEQ_INT), 32'd1);
            chk("t4_lat", 32'((cyc - lt[0]) >= 16 && (cyc - lt[0]) <= 17), 32'd1);
        end
        chk("t4_nv", 32'(nv), 32'd1);
        chk("t4_c0", {22'd0, lc[0], ld[0]}, 32'h155);
        wb_rd(6'h08, rd);
        chk("t4_stat", rd, 32'h101);
        wb_wr(6'h04, 32'h110);
        wb_rd(6'h08, rd);
        chk("t4_flush", rd, 32'h200);

        // 5: empty FIFO, START ignored while busy
        done_en = 1'b1;
        nv = 0;
        wb_wr(6'h04, 32'h03);
        wb_wr(6'h04, 32'h03);
        wait_idle("t5_idle");
        repeat (10) @(negedge CLK_I);
        chk("t5_nv", 32'(nv), 32'd2);
        chk("t5_c0", 32'(lc[0]), 32'd2);
        chk("t5_c1", 32'(lc[1]), 32'd3);
        chk("t5_oen", 32'(lo[1]), 32'd1);
        chk("t5_oen_hold", 32'(SFT_OEN), 32'd1);
        wb_wr(6'h04, 32'h10);

        // 6: reset during the second shift
        for (int i = 0; i < 3; i++) wb_wr(6'h00, 32'h70 + 32'(i));
        nv = 0;
        wb_wr(6'h04, 32'h01);
        wait_nv(2, "t6_wait");
        RST_I = 1'b1;
        #1;
        chk("t6_vld", 32'(SFT_VLD), 32'd0);
        chk("t6_oen", 32'(SFT_OEN), 32'd1);
        repeat (2) @(negedge CLK_I);
        RST_I = 1'b0;
        n0 = nv;
        repeat (20) @(negedge CLK_I);
        chk("t6_novld", 32'(nv), 32'(n0));
        wb_rd(6'h08, rd);
        chk("t6_stat", rd, 32'h200);
        chk("t6_int", 32'(SEQ_INT), 32'd0);

`ifdef SFT_SEQ_REPEAT_EN
        // repeat passes until REPEAT is dropped
        wb_wr(6'h00, 32'hA5);
        wb_wr(6'h00, 32'h3C);
        nv = 0;
        wb_wr(6'h04, 32'h25);
        wb_rd(6'h08, rd);
        chk("rp_bit", {31'd0, rd[10]}, 32'd1);
        wait_nv(12, "rp_wait");
        wb_wr(6'h04, 32'h00);
        wait_idle("rp_idle");
        chk("rp_mod", 32'(nv % 5), 32'd0);
        chk("rp_min", 32'(nv >= 15), 32'd1);
        bad = 0;
        for (int i = 0; i < nv && i < 64; i++) begin
            if (lc[i] !== 2'((i % 5) == 0 ? 0 : (i % 5) <= 2 ? 1 : (i % 5) - 1)) bad++;
            if ((i % 5) == 1 && ld[i] !== 8'hA5) bad++;
            if ((i % 5) == 2 && ld[i] !== 8'h3C) bad++;
        end
        chk("rp_pat", 32'(bad), 32'd0);
        wb_rd(6'h08, rd);
        chk("rp_stat", rd, 32'h240);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
